// File: rtl/dspl_drv_ndig.sv
// N-digit multiplexed 7-segment driver: tick-free slot scanning with
// inter-digit blanking, global PWM brightness and per-digit blink.
module dspl_drv_ndig #(
    parameter int N_DIG       = 8,
    parameter int CLK_HZ      = 100000000,
    parameter int SLOT_HZ     = 1000,
    parameter int BLANK_CYC   = 1000,
    parameter int BRIGHT_W    = 4,
    parameter int BLINK_SCANS = 62
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [6*N_DIG-1:0]   i_digits,
    input  logic [N_DIG-1:0]     i_blink_en,
    input  logic [BRIGHT_W-1:0]  i_brightness,
    output logic [N_DIG-1:0]     o_an,
    output logic [7:0]           o_dec_ddp
);

    localparam int SLOT   = CLK_HZ / SLOT_HZ;
    localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W  = $clog2(N_DIG);
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [SLOT_W-1:0]   r_slotCnt;
    logic [IDX_W-1:0]    r_idx;
    logic [BRIGHT_W-1:0] r_pwm;
    logic [SCAN_W-1:0]   r_scanCnt;
    logic                r_hidden;
    logic [5:0]          r_digLat;
    logic                r_blinkLat;
    logic [BRIGHT_W-1:0] r_brightLat;

    logic                w_slotStart;
    logic                w_slotEnd;
    logic                w_scanEnd;
    logic [5:0]          w_liveDig;
    logic [5:0]          w_dig;
    logic                w_blink;
    logic [BRIGHT_W-1:0] w_bright;
    logic                w_on;
    logic                w_lit;
    logic                w_show;
    logic [6:0]          w_seg;
    logic [N_DIG-1:0]    w_anNext;
    logic [7:0]          w_ddpNext;

    assign w_slotStart = (r_slotCnt == '0);
    assign w_slotEnd   = (r_slotCnt == SLOT_W'(SLOT - 1));
    assign w_scanEnd   = w_slotEnd && (r_idx == IDX_W'(N_DIG - 1));
    assign w_liveDig   = i_digits[6*int'(r_idx) +: 6];

    // Slot cycle 0 uses the live inputs (the same values being latched),
    // later cycles use the snapshot so mid-slot changes are ignored.
    assign w_dig    = w_slotStart ? w_liveDig : r_digLat;
    assign w_blink  = w_slotStart ? i_blink_en[r_idx] : r_blinkLat;
    assign w_bright = w_slotStart ? i_brightness : r_brightLat;

    assign w_on   = (r_slotCnt >= SLOT_W'(BLANK_CYC));
    assign w_lit  = (w_bright == '1) || (r_pwm < w_bright);
    assign w_show = w_on && w_dig[5] && w_lit && !(w_blink && r_hidden);

    // Slot counter, digit index and blink scan/phase bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slotCnt <= '0;
            r_idx     <= '0;
            r_scanCnt <= '0;
            r_hidden  <= 1'b0;
        end else if (w_slotEnd) begin
            r_slotCnt <= '0;
            if (w_scanEnd) begin
                r_idx <= '0;
                if (r_scanCnt == SCAN_W'(BLINK_SCANS - 1)) begin
                    r_scanCnt <= '0;
                    r_hidden  <= ~r_hidden;
                end else begin
                    r_scanCnt <= r_scanCnt + 1'b1;
                end
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_slotCnt <= r_slotCnt + 1'b1;
        end
    end

    // Free-running PWM phase counter for brightness.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    // Snapshot the current digit's inputs at the start of each slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digLat    <= '0;
            r_blinkLat  <= 1'b0;
            r_brightLat <= '0;
        end else if (w_slotStart) begin
            r_digLat    <= w_liveDig;
            r_blinkLat  <= i_blink_en[r_idx];
            r_brightLat <= i_brightness;
        end
    end

    // Hex to active-low segments a..g.
    always_comb begin
        w_seg = 7'b1111111;
        case (w_dig[4:1])
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            4'hF: w_seg = 7'b0111000;
            default: w_seg = 7'b1111111;
        endcase
    end

    // Next anode/cathode pattern: all dark during blanking, one anode at most.
    always_comb begin
        w_anNext  = '1;
        w_ddpNext = 8'hFF;
        if (w_on) begin
            w_ddpNext = {w_seg, w_dig[0]};
        end
        if (w_show) begin
            w_anNext[r_idx] = 1'b0;
        end
    end

    // Registered pin drivers, forced dark asynchronously on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_an      <= '1;
            o_dec_ddp <= 8'hFF;
        end else begin
            o_an      <= w_anNext;
            o_dec_ddp <= w_ddpNext;
        end
    end

endmodule

// File: tb/tb_dspl_drv_ndig.sv
// Self-checking bench for dspl_drv_ndig: a time-indexed reference model
// pushes expected pin values each clock, and they are popped and compared
// one cycle later against the registered outputs.
module tb_dspl_drv_ndig;

    localparam int N_DIG       = 4;
    localparam int CLK_HZ      = 1600;
    localparam int SLOT_HZ     = 100;
    localparam int BLANK_CYC   = 2;
    localparam int BRIGHT_W    = 4;
    localparam int BLINK_SCANS = 2;
    localparam int SLOT        = 16;
    localparam int SCAN        = SLOT * N_DIG;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] ddp;
    } expT;

    logic        clk;
    logic        rstN;
    logic [23:0] digits;
    logic [3:0]  blinkEn;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [7:0]  decDdp;

    expT         scoreQ[$];
    int          errCount;
    int          checkCount;
    int          k;
    logic [5:0]  snapDig;
    logic        snapBlink;
    logic [3:0]  snapBright;
    logic [3:0]  lastAn;
    logic [7:0]  lastDdp;

    dspl_drv_ndig #(
        .N_DIG(N_DIG), .CLK_HZ(CLK_HZ), .SLOT_HZ(SLOT_HZ),
        .BLANK_CYC(BLANK_CYC), .BRIGHT_W(BRIGHT_W), .BLINK_SCANS(BLINK_SCANS)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_digits(digits),
        .i_blink_en(blinkEn),
        .i_brightness(brightness),
        .o_an(an),
        .o_dec_ddp(decDdp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment table written out from the display datasheet pattern list.
    function automatic logic [6:0] segOf(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    function automatic logic [5:0] mkDig(input logic en, input logic [3:0] val, input logic dp);
        return {en, val, dp};
    endfunction

    // Expected pins for the state reached kk clocks after reset release.
    function automatic expT modelOut(input int kk, input logic [5:0] dig,
                                     input logic blink, input logic [3:0] bright);
        expT e;
        int  slotc;
        int  idx;
        int  pwm;
        bit  hidden;
        bit  lit;
        slotc  = kk % SLOT;
        idx    = (kk / SLOT) % N_DIG;
        pwm    = kk % 16;
        hidden = (((kk / SCAN) / BLINK_SCANS) % 2) == 1;
        e.an   = 4'hF;
        e.ddp  = 8'hFF;
        if (slotc >= BLANK_CYC) begin
            e.ddp = {segOf(dig[4:1]), dig[0]};
            lit   = (bright == 4'hF) || (pwm < int'(bright));
            if (dig[5] && lit && !(blink && hidden)) e.an[idx] = 1'b0;
        end
        return e;
    endfunction

    task automatic pushExpected();
        int idx;
        if (!rstN) begin
            scoreQ.push_back({4'hF, 8'hFF});
        end else begin
            if (k % SLOT == 0) begin
                idx        = (k / SLOT) % N_DIG;
                snapDig    = digits[6*idx +: 6];
                snapBlink  = blinkEn[idx];
                snapBright = brightness;
            end
            scoreQ.push_back(modelOut(k, snapDig, snapBlink, snapBright));
            k++;
        end
    endtask

    task automatic checkOutput(input string tag);
        expT e;
        if (scoreQ.size() == 0) begin
            checkCount++;
            errCount++;
            $error("[TB] FAIL %s scoreboard empty observed an=%b", tag, an);
        end else begin
            e = scoreQ.pop_front();
            checkCount++;
            assert (an === e.an) else begin
                errCount++;
                $error("[TB] FAIL %s_an k=%0d observed=%b expected=%b", tag, k - 1, an, e.an);
            end
            checkCount++;
            assert (decDdp === e.ddp) else begin
                errCount++;
                $error("[TB] FAIL %s_ddp k=%0d observed=%b expected=%b", tag, k - 1, decDdp, e.ddp);
            end
        end
        lastAn  = an;
        lastDdp = decDdp;
    endtask

    task automatic checkCond(input string tag, input int obs, input int exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        pushExpected();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic alignScan();
        for (int i = 0; i < SCAN && (k % SCAN) != 0; i++) tick("align");
    endtask

    task automatic applyStimulus(input logic [23:0] d, input logic [3:0] b, input logic [3:0] br);
        digits     = d;
        blinkEn    = b;
        brightness = br;
    endtask

    // Global time limit so the run always reaches an end.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence of test steps.
    initial begin
        logic [23:0] baseDigits;
        int firstK;
        int lowCnt[4];
        int lo0;
        int lo1;
        int sc;
        bit hid;
        int an2Low;
        int dp1Low;
        int dp1High;

        errCount   = 0;
        checkCount = 0;
        k          = 0;
        snapDig    = '0;
        snapBlink  = 1'b0;
        snapBright = '0;
        lastAn     = 4'hF;
        lastDdp    = 8'hFF;
        baseDigits = {mkDig(1'b1, 4'h4, 1'b1), mkDig(1'b1, 4'h3, 1'b1),
                      mkDig(1'b1, 4'h2, 1'b1), mkDig(1'b1, 4'h1, 1'b1)};

        // Reset held, then release and find the first lit anode.
        rstN = 1'b0;
        applyStimulus({4{6'h3F}}, 4'b0000, 4'hF);
        runCycles(4, "reset");
        checkCond("resetAn", int'(an), 15);
        checkCond("resetDdp", int'(decDdp), 255);
        rstN   = 1'b1;
        k      = 0;
        firstK = -1;
        for (int i = 0; i < 40 && firstK < 0; i++) begin
            tick("release");
            if (lastAn !== 4'hF) firstK = k - 1;
        end
        checkCond("firstOnState", firstK, 2);
        checkCond("firstOnAn", int'(lastAn), 4'b1110);

        // Values 1..4, full brightness: each digit lit 14 cycles per scan.
        applyStimulus(baseDigits, 4'b0000, 4'hF);
        alignScan();
        for (int d = 0; d < 4; d++) lowCnt[d] = 0;
        for (int i = 0; i < SCAN; i++) begin
            tick("scan");
            for (int d = 0; d < 4; d++) if (!lastAn[d]) lowCnt[d]++;
        end
        for (int d = 0; d < 4; d++) checkCond($sformatf("onCycles%0d", d), lowCnt[d], 14);

        // Brightness zero keeps everything dark; half brightness halves duty.
        applyStimulus(baseDigits, 4'b0000, 4'h0);
        alignScan();
        lo0 = 0;
        for (int i = 0; i < SCAN; i++) begin
            tick("dark");
            if (lastAn !== 4'hF) lo0++;
        end
        checkCond("brightZero", lo0, 0);
        applyStimulus(baseDigits, 4'b0000, 4'h8);
        alignScan();
        lo0 = 0;
        for (int i = 0; i < SCAN; i++) begin
            tick("half");
            if (!lastAn[0]) lo0++;
        end
        checkCond("brightHalfInRange", int'(lo0 >= 6 && lo0 <= 8), 1);

        // Blink digit 0 only: two scans visible, two hidden.
        applyStimulus(baseDigits, 4'b0001, 4'hF);
        alignScan();
        for (int s = 0; s < 4; s++) begin
            sc  = k / SCAN;
            hid = ((sc / BLINK_SCANS) % 2) == 1;
            lo0 = 0;
            lo1 = 0;
            for (int i = 0; i < SCAN; i++) begin
                tick("blink");
                if (!lastAn[0]) lo0++;
                if (!lastAn[1]) lo1++;
            end
            checkCond("blinkDig0", lo0, hid ? 0 : 14);
            checkCond("blinkDig1", lo1, 14);
        end

        // Digit 2 disabled, digit 1 decimal point on.
        applyStimulus({mkDig(1'b1, 4'h4, 1'b1), mkDig(1'b0, 4'h3, 1'b0),
                       mkDig(1'b1, 4'h2, 1'b0), mkDig(1'b1, 4'h1, 1'b1)}, 4'b0000, 4'hF);
        alignScan();
        an2Low  = 0;
        dp1Low  = 0;
        dp1High = 0;
        for (int i = 0; i < 10 * SCAN; i++) begin
            tick("enDp");
            if (!lastAn[2]) an2Low++;
            if (lastAn == 4'b1101) begin
                if (!lastDdp[0]) dp1Low++;
                else dp1High++;
            end
        end
        checkCond("disabledDigit", an2Low, 0);
        checkCond("dp1On", dp1Low, 140);
        checkCond("dp1Off", dp1High, 0);

        // Reset pulsed at slot cycle 9 of digit 1.
        applyStimulus(baseDigits, 4'b0000, 4'hF);
        for (int i = 0; i < 2 * SCAN && (k % SCAN) != (SLOT + 9); i++) tick("seek");
        checkCond("preResetAn", int'(lastAn), 4'b1101);
        rstN = 1'b0;
        #1;
        checkCond("asyncResetAn", int'(an), 15);
        checkCond("asyncResetDdp", int'(decDdp), 255);
        k = 0;
        runCycles(3, "inReset");
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick("restart");
            if (i == 2) checkCond("restartAn", int'(lastAn), 4'b1110);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
